// File: rtl/program_loader.sv
// Boot loader: assembles a length-prefixed little-endian byte stream into 32-bit words,
// writes them to program memory, and holds the core in reset until the image is complete.
module program_loader #(
    parameter int MEMORY_DEPTH = 256,
    parameter int DATA_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  byte_valid_i,
    input  logic [7:0]            byte_i,
    output logic                  byte_ready_o,
    output logic                  mem_write_o,
    output logic [31:0]           mem_address_o,
    output logic [DATA_WIDTH-1:0] mem_data_o,
    output logic                  cpu_reset_o,
    output logic                  loaded_o,
    output logic                  error_o,
    output logic [15:0]           words_loaded_o
);

    typedef enum logic [2:0] {LEN0, LEN1, DATA, WRITE, DONE, ERR} state_t;

    state_t                state_q, state_d;
    logic [15:0]           len_q, len_d;
    logic [23:0]           buf_q, buf_d;
    logic [1:0]            k_q, k_d;
    logic [15:0]           words_q, words_d;
    logic [31:0]           addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  ready_q, write_q, cpu_rst_q, loaded_q, error_q;

    logic        accept;
    logic [15:0] len_full;
    logic [15:0] words_inc;

    assign accept    = byte_valid_i & ready_q;
    assign len_full  = {byte_i, len_q[7:0]};
    assign words_inc = words_q + 16'd1;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        buf_d   = buf_q;
        k_d     = k_q;
        words_d = words_q;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            LEN0: if (accept) begin
                len_d[7:0] = byte_i;
                state_d    = LEN1;
            end
            LEN1: if (accept) begin
                len_d[15:8] = byte_i;
                if (len_full == 16'd0)
                    state_d = DONE;
                else if ({16'd0, len_full} > 32'(MEMORY_DEPTH))
                    state_d = ERR;
                else
                    state_d = DATA;
            end
            DATA: if (accept) begin
                k_d = k_q + 2'd1;
                case (k_q)
                    2'd0: buf_d[7:0]   = byte_i;
                    2'd1: buf_d[15:8]  = byte_i;
                    2'd2: buf_d[23:16] = byte_i;
                    default: begin
                        // Last byte goes straight into the word; the write cycle only presents it.
                        data_d  = DATA_WIDTH'({byte_i, buf_q});
                        addr_d  = {14'd0, words_q, 2'b00};
                        state_d = WRITE;
                    end
                endcase
            end
            WRITE: begin
                words_d = words_inc;
                state_d = (words_inc == len_q) ? DONE : DATA;
            end
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= LEN0;
            len_q     <= '0;
            buf_q     <= '0;
            k_q       <= '0;
            words_q   <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            ready_q   <= 1'b0;
            write_q   <= 1'b0;
            cpu_rst_q <= 1'b1;
            loaded_q  <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            buf_q     <= buf_d;
            k_q       <= k_d;
            words_q   <= words_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            // Status flags are decoded from the next state so they line up with state_q.
            ready_q   <= (state_d == LEN0) || (state_d == LEN1) || (state_d == DATA);
            write_q   <= (state_d == WRITE);
            cpu_rst_q <= (state_d != DONE);
            loaded_q  <= (state_d == DONE);
            error_q   <= (state_d == ERR);
        end
    end

    assign byte_ready_o   = ready_q;
    assign mem_write_o    = write_q;
    assign mem_address_o  = addr_q;
    assign mem_data_o     = data_q;
    assign cpu_reset_o    = cpu_rst_q;
    assign loaded_o       = loaded_q;
    assign error_o        = error_q;
    assign words_loaded_o = words_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: one task per scenario, inline checks.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_ready, mem_write, cpu_reset, loaded, error_flag;
    logic [31:0] mem_address, mem_data;
    logic [15:0] words_loaded;

    int errors = 0;
    int checks = 0;
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];

    program_loader #(.MEMORY_DEPTH(256), .DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .byte_valid_i(byte_valid), .byte_i(byte_in), .byte_ready_o(byte_ready),
        .mem_write_o(mem_write), .mem_address_o(mem_address), .mem_data_o(mem_data),
        .cpu_reset_o(cpu_reset), .loaded_o(loaded), .error_o(error_flag),
        .words_loaded_o(words_loaded)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_write) begin
            wr_addr.push_back(mem_address);
            wr_data.push_back(mem_data);
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        byte_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        wr_addr.delete();
        wr_data.delete();
    endtask

    // Presents a byte and holds it until the accepting edge; returns #1 after that edge.
    task automatic send_byte(input logic [7:0] b);
        bit ok = 0;
        byte_valid = 1'b1;
        byte_in = b;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (byte_ready) begin ok = 1; break; end
        end
        @(posedge clk);
        #1 byte_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL accept_timeout byte=%h ready=%b required ready=1", b, byte_ready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({byte_ready, mem_write, loaded, error_flag, cpu_reset} !== 5'b00001) begin
            errors++;
            $display("FAIL reset_flags got rdy/wr/ld/err/cpu=%b required 00001",
                     {byte_ready, mem_write, loaded, error_flag, cpu_reset});
        end
        checks++;
        if ({mem_address, mem_data, words_loaded} !== 80'd0) begin
            errors++;
            $display("FAIL reset_data addr=%h data=%h words=%0d required all 0",
                     mem_address, mem_data, words_loaded);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if (byte_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_early got %b required 0", byte_ready);
        end
        @(negedge clk);
        checks++;
        if (byte_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset got %b required 1", byte_ready);
        end
    endtask

    task automatic test_single();
        logic [7:0] s [6] = '{8'h01, 8'h00, 8'h20, 8'h08, 8'h00, 8'h05};
        do_reset();
        foreach (s[i]) send_byte(s[i]);
        @(negedge clk);
        checks++;
        if ({mem_write, cpu_reset, byte_ready} !== 3'b110 || mem_address !== 32'h0 ||
            mem_data !== 32'h05000820) begin
            errors++;
            $display("FAIL single_write wr=%b cpu=%b rdy=%b addr=%h data=%h required 1 1 0 0 05000820",
                     mem_write, cpu_reset, byte_ready, mem_address, mem_data);
        end
        @(negedge clk);
        checks++;
        if ({mem_write, cpu_reset, loaded} !== 3'b001 || words_loaded !== 16'd1 ||
            mem_data !== 32'h05000820) begin
            errors++;
            $display("FAIL single_done wr=%b cpu=%b ld=%b words=%0d data=%h required 0 0 1 1 05000820",
                     mem_write, cpu_reset, loaded, words_loaded, mem_data);
        end
    endtask

    task automatic test_gaps();
        logic [7:0]  s [14] = '{8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                                8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h01, 8'h02, 8'h03, 8'h04};
        logic [31:0] exp_d [3] = '{32'h44332211, 32'hDDCCBBAA, 32'h04030201};
        do_reset();
        foreach (s[i]) begin
            send_byte(s[i]);
            @(posedge clk);
            #1;
        end
        repeat (3) @(negedge clk);
        checks++;
        if (wr_addr.size() != 3) begin
            errors++;
            $display("FAIL gaps_count got %0d writes required 3", wr_addr.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (wr_addr[i] !== 32'(i * 4) || wr_data[i] !== exp_d[i]) begin
                    errors++;
                    $display("FAIL gaps_word%0d addr=%h data=%h required %h %h",
                             i, wr_addr[i], wr_data[i], 32'(i * 4), exp_d[i]);
                end
            end
        end
        checks++;
        if (words_loaded !== 16'd3 || loaded !== 1'b1 || cpu_reset !== 1'b0) begin
            errors++;
            $display("FAIL gaps_done words=%0d ld=%b cpu=%b required 3 1 0",
                     words_loaded, loaded, cpu_reset);
        end
    endtask

    task automatic test_zero();
        do_reset();
        send_byte(8'h00);
        send_byte(8'h00);
        @(negedge clk);
        checks++;
        if ({cpu_reset, loaded, byte_ready, mem_write} !== 4'b0100 || wr_addr.size() != 0) begin
            errors++;
            $display("FAIL zero_len cpu=%b ld=%b rdy=%b wr=%b writes=%0d required 0 1 0 0 0",
                     cpu_reset, loaded, byte_ready, mem_write, wr_addr.size());
        end
    endtask

    task automatic test_error();
        bit ready_seen = 0;
        do_reset();
        send_byte(8'h01);
        send_byte(8'h01);
        @(negedge clk);
        checks++;
        if ({error_flag, cpu_reset, byte_ready, loaded} !== 4'b1100) begin
            errors++;
            $display("FAIL err_flags err=%b cpu=%b rdy=%b ld=%b required 1 1 0 0",
                     error_flag, cpu_reset, byte_ready, loaded);
        end
        byte_valid = 1'b1;
        byte_in = 8'h77;
        repeat (8) begin
            @(negedge clk);
            if (byte_ready) ready_seen = 1;
        end
        byte_valid = 1'b0;
        checks++;
        if (ready_seen || wr_addr.size() != 0 || error_flag !== 1'b1 || cpu_reset !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky ready_seen=%b writes=%0d err=%b cpu=%b required 0 0 1 1",
                     ready_seen, wr_addr.size(), error_flag, cpu_reset);
        end
    endtask

    task automatic test_midreset();
        logic [7:0] s [7] = '{8'h02, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h99};
        logic [7:0] f [6] = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
        do_reset();
        foreach (s[i]) send_byte(s[i]);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({byte_ready, mem_write, loaded, error_flag, cpu_reset} !== 5'b00001 ||
            words_loaded !== 16'd0 || mem_address !== 32'd0 || mem_data !== 32'd0) begin
            errors++;
            $display("FAIL midreset_state flags=%b words=%0d addr=%h data=%h required 00001 0 0 0",
                     {byte_ready, mem_write, loaded, error_flag, cpu_reset},
                     words_loaded, mem_address, mem_data);
        end
        do_reset();
        foreach (f[i]) send_byte(f[i]);
        repeat (2) @(negedge clk);
        checks++;
        if (wr_addr.size() != 1 || wr_addr[0] !== 32'h0 || wr_data[0] !== 32'h12345678 ||
            words_loaded !== 16'd1 || loaded !== 1'b1) begin
            errors++;
            $display("FAIL midreset_reload writes=%0d words=%0d ld=%b required 1 write 0:12345678 words=1 ld=1",
                     wr_addr.size(), words_loaded, loaded);
        end
    endtask

    task automatic test_full();
        int bad = 0;
        bit accepted = 0;
        do_reset();
        send_byte(8'h00);
        send_byte(8'h01);
        for (int w = 0; w < 256; w++) begin
            send_byte(8'(w));
            send_byte(~8'(w));
            send_byte(8'h5A);
            send_byte(8'hC3);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (wr_addr.size() != 256) begin
            errors++;
            $display("FAIL full_count got %0d writes required 256", wr_addr.size());
        end else begin
            for (int w = 0; w < 256; w++)
                if (wr_addr[w] !== 32'(w * 4) || wr_data[w] !== {8'hC3, 8'h5A, ~8'(w), 8'(w)}) bad++;
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL full_words %0d of 256 words wrong required 0", bad);
            end
            checks++;
            if (wr_addr[255] !== 32'h3FC || wr_data[255] !== 32'hC35A00FF) begin
                errors++;
                $display("FAIL full_last addr=%h data=%h required 000003fc c35a00ff",
                         wr_addr[255], wr_data[255]);
            end
        end
        checks++;
        if (words_loaded !== 16'd256 || loaded !== 1'b1 || cpu_reset !== 1'b0) begin
            errors++;
            $display("FAIL full_done words=%0d ld=%b cpu=%b required 256 1 0",
                     words_loaded, loaded, cpu_reset);
        end
        byte_valid = 1'b1;
        byte_in = 8'hEE;
        repeat (10) begin
            @(negedge clk);
            if (byte_ready) accepted = 1;
        end
        byte_valid = 1'b0;
        checks++;
        if (accepted || wr_addr.size() != 256 || loaded !== 1'b1) begin
            errors++;
            $display("FAIL full_extra ready_seen=%b writes=%0d ld=%b required 0 256 1",
                     accepted, wr_addr.size(), loaded);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_gaps();
        test_zero();
        test_error();
        test_midreset();
        test_full();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
